// File: rtl/syst_ws_collector.sv
// syst_ws_collector: aligns skewed y1/y2 outputs of syst_ws into pairs and
// buffers them in a small FIFO behind a valid/ready stream.
module syst_ws_collector #(
  parameter int DATA_W     = 19,
  parameter int Y1_LAT     = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          vec_valid_i,
  input  logic [DATA_W-1:0]             y1_i,
  input  logic [DATA_W-1:0]             y2_i,
  output logic                          m_valid_o,
  input  logic                          m_ready_i,
  output logic [DATA_W-1:0]             m_y1_o,
  output logic [DATA_W-1:0]             m_y2_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o,
  output logic                          overflow_o,
  input  logic                          overflow_clr_i
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [Y1_LAT:0]   tag_q, tag_d;
  logic [DATA_W-1:0] y1_hold_q, y1_hold_d;
  logic [DATA_W-1:0] mem1_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem2_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              push, pop, full, wr_en;
  // The last tag stage doubles as hold_tag: y1_hold is valid and y2 is due now.
  assign push  = tag_q[Y1_LAT];
  assign pop   = m_valid_o & m_ready_i;
  assign full  = cnt_q == (AW+1)'(FIFO_DEPTH);
  assign wr_en = push & (~full | pop);
  always_comb begin
    tag_d     = {tag_q[Y1_LAT-1:0], vec_valid_i};
    y1_hold_d = tag_q[Y1_LAT-1] ? y1_i : y1_hold_q;
    wr_d      = wr_en ? wr_q + 1'b1 : wr_q;
    rd_d      = pop ? rd_q + 1'b1 : rd_q;
    cnt_d     = cnt_q + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, pop};
    ovf_d     = (push & full & ~pop) | (ovf_q & ~overflow_clr_i);
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      tag_q     <= '0;
      y1_hold_q <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      tag_q     <= tag_d;
      y1_hold_q <= y1_hold_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
    end
  end
  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem1_q[wr_q] <= y1_hold_q;
      mem2_q[wr_q] <= y2_i;
    end
  end
  assign m_valid_o  = cnt_q != '0;
  assign m_y1_o     = m_valid_o ? mem1_q[rd_q] : '0;
  assign m_y2_o     = m_valid_o ? mem2_q[rd_q] : '0;
  assign count_o    = cnt_q;
  assign overflow_o = ovf_q;
endmodule
